// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB first,
// through a DIGIT-wide adder with a registered carry; result lands with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, done_q, done_d;
  logic [DIGIT-1:0] dig;
  logic             dig_c;
  logic             load, last_step;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  assign {dig_c, dig} = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], c_q);
  assign load         = (state_q == IDLE) && start;
  assign last_step    = (state_q == RUN) && (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // Each step shifts the new digit in at the top so the first digit ends at bit 0.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    s_d    = s_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    done_d = 1'b0;
    if (load) begin
      a_d   = a;
      b_d   = b;
      c_d   = cin;
      s_d   = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      s_d   = (s_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
      c_d   = dig_c;
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        sum_d  = s_d;
        cout_d = dig_c;
        done_d = 1'b1;
      end
    end
  end

  // Working operands are always reloaded on start, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    s_q <= s_d;
    c_q <= c_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      done_q <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8x1, 8x4, 4x2) checked against
// a plain-arithmetic model of a+b+cin.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       st0, st1, st2;
  logic [7:0] a0, b0, a1, b1;
  logic [3:0] a2, b2;
  logic       c0, c1, c2;
  logic       busy0, busy1, busy2, done0, done1, done2, co0, co1, co2;
  logic [7:0] sum0, sum1;
  logic [3:0] sum2;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_8x1 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .cin(c0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(co0));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_8x4 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(co1));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u_4x2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(c2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(co2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [7:0] ta,
                       input logic [7:0] tb, input logic tc);
    case (s)
      0:       begin st0 = st; a0 = ta; b0 = tb; c0 = tc; end
      1:       begin st1 = st; a1 = ta; b1 = tb; c1 = tc; end
      default: begin st2 = st; a2 = ta[3:0]; b2 = tb[3:0]; c2 = tc; end
    endcase
  endtask

  function automatic logic f_busy(input int s);
    return (s == 0) ? busy0 : (s == 1) ? busy1 : busy2;
  endfunction
  function automatic logic f_done(input int s);
    return (s == 0) ? done0 : (s == 1) ? done1 : done2;
  endfunction
  function automatic logic f_cout(input int s);
    return (s == 0) ? co0 : (s == 1) ? co1 : co2;
  endfunction
  function automatic logic [7:0] f_sum(input int s);
    return (s == 0) ? sum0 : (s == 1) ? sum1 : {4'b0, sum2};
  endfunction
  function automatic int wid(input int s);
    return (s == 2) ? 4 : 8;
  endfunction
  function automatic int nsteps(input int s);
    return (s == 0) ? 8 : 2;
  endfunction

  // One isolated addition on instance s, with latency and single-pulse checks.
  task automatic op(input int s, input logic [7:0] ta, input logic [7:0] tb,
                    input logic tc, input string tag);
    int  n, full, w;
    bit  seen;
    w    = wid(s);
    full = (int'(ta) % (1 << w)) + (int'(tb) % (1 << w)) + int'(tc);
    @(negedge clk);
    drive(s, 1'b1, ta, tb, tc);
    @(negedge clk);
    drive(s, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    n    = 0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (f_done(s)) begin
        seen = 1;
        break;
      end
      if (f_busy(s)) n++;
      @(negedge clk);
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " busy_cycles"}, 32'(n), 32'(nsteps(s)));
    check({tag, " busy_at_done"}, 32'(f_busy(s)), 32'd0);
    check({tag, " sum"}, 32'(f_sum(s)), 32'(full % (1 << w)));
    check({tag, " cout"}, 32'(f_cout(s)), 32'(full >> w));
    @(negedge clk);
    check({tag, " one_pulse"}, 32'(f_done(s)), 32'd0);
  endtask

  initial begin
    int dones;
    logic [7:0] cap_sum;
    logic cap_cout;

    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset busy%0d", s), 32'(f_busy(s)), 32'd0);
      check($sformatf("reset done%0d", s), 32'(f_done(s)), 32'd0);
      check($sformatf("reset sum%0d", s),  32'(f_sum(s)),  32'd0);
      check($sformatf("reset cout%0d", s), 32'(f_cout(s)), 32'd0);
    end
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      dones += int'(done0) + int'(done1) + int'(done2);
    end
    check("idle no_done", 32'(dones), 32'd0);

    op(0, 8'hFF, 8'h01, 1'b0, "8x1 ff+01");
    op(1, 8'hA5, 8'h5A, 1'b1, "8x4 a5+5a+1");
    op(1, 8'h12, 8'h34, 1'b0, "8x4 12+34");
    for (int i = 0; i < 8; i++) begin
      op(0, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("8x1 rand%0d", i));
      op(1, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("8x4 rand%0d", i));
    end

    // Back-to-back: each new start is issued in the done cycle of the previous add.
    for (int i = 0; i < 512; i++) begin
      int ta, tb, tc, k;
      ta = i & 15;
      tb = (i >> 4) & 15;
      tc = (i >> 8) & 1;
      drive(2, 1'b1, 8'(ta), 8'(tb), 1'(tc));
      @(negedge clk);
      drive(2, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      k = 1;
      while (!done2 && k < 10) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("exh spacing %0d", i), 32'(k), 32'd3);
      check($sformatf("exh result %0d", i), {27'b0, co2, sum2}, 32'(ta + tb + tc));
    end
    @(negedge clk);
    check("exh done_falls", 32'(done2), 32'd0);

    // Second start three cycles into a busy add must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 8'h3C, 8'h41, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 8'hF0, 8'h0F, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    dones    = 0;
    cap_sum  = 8'h00;
    cap_cout = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done0) begin
        dones++;
        cap_sum  = sum0;
        cap_cout = co0;
      end
      @(negedge clk);
    end
    check("ignored_start dones", 32'(dones), 32'd1);
    check("ignored_start sum", 32'(cap_sum), 32'h7D);
    check("ignored_start cout", 32'(cap_cout), 32'd0);

    // Reset four cycles into an 8-cycle add.
    drive(0, 1'b1, 8'h11, 8'h22, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy0), 32'd0);
    check("midreset sum", 32'(sum0), 32'd0);
    check("midreset cout", 32'(co0), 32'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      dones += int'(done0);
      if (k == 2) rst_n = 1'b1;
    end
    check("midreset no_done", 32'(dones), 32'd0);
    check("midreset busy_after", 32'(busy0), 32'd0);
    op(0, 8'h80, 8'h80, 1'b0, "8x1 after_reset 80+80");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
